// File: rtl/riscv_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory responder.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } imem_state_e;

    // Word index of a byte address widened so it can be range-checked against any depth.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, combinational read, never reset.
module imem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Indices past DEPTH only occur for non power-of-two depths; the caller masks them anyway.
    assign rd_data = (32'(rd_idx) < 32'(DEPTH)) ? mem[rd_idx] : 32'h0;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch, waits WAIT_CYCLES, holds the response until acked.
// Optional IMEM_ALIGN_CHECK_EN: misaligned fetch addresses answer with NOP and fetch_err.
module imem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,
    output logic        fetch_err,
    input  logic        fetch_ack,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    imem_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;

    logic          idle;
    logic          accept;
    logic [31:0]   sel_addr;
    logic          bad_addr;
    logic [31:0]   rd_data;
    logic [31:0]   resp_word;
    logic          wr_en;
    logic          unused_ok;

    assign idle        = (state_q == ST_IDLE);
    assign fetch_ready = idle && !load_en;
    assign accept      = fetch_req && fetch_ready;
    assign busy        = !idle;
    assign fetch_valid = (state_q == ST_RESP);
    assign fetch_data  = data_q;
    assign fetch_err   = err_q;

    // With zero wait the response is captured on the accepting edge, so read the live address.
    assign sel_addr = idle ? fetch_addr : addr_q;

`ifdef IMEM_ALIGN_CHECK_EN
    assign bad_addr = (word_index(sel_addr) >= 32'(DEPTH_WORDS)) || (sel_addr[1:0] != 2'b00);
`else
    assign bad_addr = (word_index(sel_addr) >= 32'(DEPTH_WORDS));
`endif

    assign resp_word = bad_addr ? NOP_INSTR : rd_data;
    assign wr_en     = load_en && idle && (word_index(load_addr) < 32'(DEPTH_WORDS));
    assign unused_ok = ^{load_addr[1:0], sel_addr[1:0]};

    imem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_idx  (load_addr[AW+1:2]),
        .wr_data (load_data),
        .rd_idx  (sel_addr[AW+1:2]),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d = fetch_addr;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        data_d  = resp_word;
                        err_d   = bad_addr;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CW'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_RESP;
                    data_d  = resp_word;
                    err_d   = bad_addr;
                end
            end
            ST_RESP: begin
                if (fetch_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: vector table of fetches plus hand-written corner sequences.
module tb_imem_responder;

    localparam int DEPTH = 64;
    localparam int W     = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_err;
    logic        fetch_ack = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    imem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_err   (fetch_err),
        .fetch_ack   (fetch_ack),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    // Called just after the accepting edge: checks latency, payload, then acks.
    task automatic finish_fetch(input string name, input logic [31:0] exp_d, input logic exp_e);
        logic early;
        early = 1'b0;
        for (int n = 0; n < W; n++) begin
            if (fetch_valid !== 1'b0) early = 1'b1;
            tick();
        end
        check({name, " early_valid"}, {31'b0, early}, 32'h0);
        check({name, " valid"}, {31'b0, fetch_valid}, 32'h1);
        check({name, " data"}, fetch_data, exp_d);
        check({name, " err"}, {31'b0, fetch_err}, {31'b0, exp_e});
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        check({name, " valid_after_ack"}, {31'b0, fetch_valid}, 32'h0);
        check({name, " ready_after_ack"}, {31'b0, fetch_ready}, 32'h1);
    endtask

    task automatic fetch(input string name, input logic [31:0] a,
                         input logic [31:0] exp_d, input logic exp_e);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req = 1'b0;
        finish_fetch(name, exp_d, exp_e);
    endtask

    initial begin
        logic [31:0] held;

        vecs[0] = '{"w0",      32'h0000_0000, 32'h0050_0093, 1'b0};
        vecs[1] = '{"w1",      32'h0000_0004, 32'h0010_0113, 1'b0};
        vecs[2] = '{"w63",     32'h0000_00FC, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{"oor100",  32'h0000_0100, NOP,           1'b1};
        vecs[4] = '{"oorhigh", 32'h8000_0000, NOP,           1'b1};
`ifdef IMEM_ALIGN_CHECK_EN
        vecs[5] = '{"misalign", 32'h0000_0002, NOP,          1'b1};
`else
        vecs[5] = '{"misalign", 32'h0000_0002, 32'h0050_0093, 1'b0};
`endif

        #3;
        check("rst valid", {31'b0, fetch_valid}, 32'h0);
        check("rst busy",  {31'b0, busy},        32'h0);
        check("rst data",  fetch_data,           32'h0);
        check("rst err",   {31'b0, fetch_err},   32'h0);
        check("rst ready", {31'b0, fetch_ready}, 32'h1);
        #9 reset = 1'b1;
        tick();

        load_word(32'h0000_0000, 32'h0050_0093);
        load_word(32'h0000_0004, 32'h0010_0113);
        load_word(32'h0000_00FC, 32'hDEAD_BEEF);
        load_word(32'h0000_0100, 32'h1234_5678);

        for (int i = 0; i < 6; i++) begin
            fetch(vecs[i].name, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Response must hold while ack stays low.
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0004;
        tick();
        fetch_req = 1'b0;
        repeat (W) tick();
        held = fetch_data;
        check("hold first data", held, 32'h0010_0113);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("hold valid", {31'b0, fetch_valid}, 32'h1);
            check("hold data", fetch_data, 32'h0010_0113);
        end
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        check("hold ready_after_ack", {31'b0, fetch_ready}, 32'h1);
        check("hold busy_after_ack",  {31'b0, busy},        32'h0);

        // Simultaneous load and fetch: write wins, fetch taken next cycle.
        load_en    = 1'b1;
        load_addr  = 32'h0000_0008;
        load_data  = 32'h0030_0193;
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0008;
        #1;
        check("collide ready", {31'b0, fetch_ready}, 32'h0);
        tick();
        load_en = 1'b0;
        check("collide not_accepted", {31'b0, busy}, 32'h0);
        tick();
        fetch_req = 1'b0;
        check("collide accepted", {31'b0, busy}, 32'h1);
        finish_fetch("collide", 32'h0030_0193, 1'b0);

        // Asynchronous reset while waiting; memory must survive.
        fetch_req  = 1'b1;
        fetch_addr = 32'h0000_0000;
        tick();
        fetch_req = 1'b0;
        check("rstwait busy_before", {31'b0, busy}, 32'h1);
        reset = 1'b0;
        #1;
        check("rstwait valid", {31'b0, fetch_valid}, 32'h0);
        check("rstwait busy",  {31'b0, busy},        32'h0);
        check("rstwait data",  fetch_data,           32'h0);
        #2 reset = 1'b1;
        tick();
        fetch("after_rst w0", 32'h0000_0000, 32'h0050_0093, 1'b0);
        fetch("after_rst w63", 32'h0000_00FC, 32'hDEAD_BEEF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
